bus_timer_array: RTL

BUS_TIMER_ARRAY -- requirements
Module: bus_timer_array

---
 rtl/bus_timer_array.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/bus_timer_array.sv
// bus_timer_array
//   A bank of NUM_CH independent periodic/one-shot timers behind a small
//   byte-wide register window on a shared processor bus. All channels share a
//   single prescaler that produces a one-cycle TICK every PRESCALE clocks.
//
//   Register map, channel c at BASE_ADDR + 4c:
//     +0 PERIOD_LO   +1 PERIOD_HI
//     +2 CTRL        bit0 EN, bit1 ONESHOT, bit2 IE
//     +3 STATUS      bit0 PEND, bit1 RUN (=EN); write bit0=1 clears PEND,
//                    any write clears COUNT
//
// Ports
//   CLK                  system clock, rising edge
//   RESET                asynchronous, active-high reset
//   BUS_DATA             bidirectional data bus, driven only for read data
//   BUS_ADDR             bus address
//   BUS_WE               bus write enable
//   BUS_INTERRUPTS_RAISE per-channel registered interrupt request
//   BUS_INTERRUPTS_ACK   per-channel interrupt acknowledge
module bus_timer_array #(
  parameter int         NUM_CH    = 2,
  parameter logic [7:0] BASE_ADDR = 8'hF0,
  parameter int         PRESCALE  = 100000
) (
  input  logic              CLK,
  input  logic              RESET,
  inout  wire  [7:0]        BUS_DATA,
  input  logic [7:0]        BUS_ADDR,
  input  logic              BUS_WE,
  output logic [NUM_CH-1:0] BUS_INTERRUPTS_RAISE,
  input  logic [NUM_CH-1:0] BUS_INTERRUPTS_ACK
);

  // Window bounds are held in 9 bits so a window ending at 8'hFF does not wrap.
  localparam logic [8:0]  WIN_LO       = {1'b0, BASE_ADDR};
  localparam logic [8:0]  WIN_HI       = WIN_LO + 9'(4 * NUM_CH);
  localparam logic [31:0] PRESCALE_MAX = 32'(PRESCALE - 1);

  logic              in_window;
  logic [3:0]        offset;
  logic [1:0]        sel_ch;
  logic [1:0]        sel_reg;
  logic              wr_en;
  logic              rd_en;
  logic [NUM_CH-1:0] ch_wr;

  logic [31:0] presc_q, presc_d;
  logic        tick;

  logic [NUM_CH-1:0][15:0] period_q, period_d;
  logic [NUM_CH-1:0][15:0] count_q, count_d;
  logic [NUM_CH-1:0]       en_q, en_d;
  logic [NUM_CH-1:0]       oneshot_q, oneshot_d;
  logic [NUM_CH-1:0]       ie_q, ie_d;
  logic [NUM_CH-1:0]       pend_q, pend_d;
  logic [NUM_CH-1:0]       raise_q, raise_d;
  logic [NUM_CH-1:0]       fire;

  logic [7:0] rd_value;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;

  // Address decode: offset within the window selects channel and register.
  assign in_window = ({1'b0, BUS_ADDR} >= WIN_LO) && ({1'b0, BUS_ADDR} < WIN_HI);
  assign offset    = 4'(BUS_ADDR - BASE_ADDR);
  assign sel_ch    = offset[3:2];
  assign sel_reg   = offset[1:0];
  assign wr_en     = BUS_WE && in_window;
  assign rd_en     = !BUS_WE && in_window;

  always_comb begin
    ch_wr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_wr[c] = wr_en && (sel_ch == 2'(c));
    end
  end

  // Shared prescaler; TICK is the wrap cycle.
  assign tick = (presc_q == PRESCALE_MAX);

  always_comb begin
    presc_d = tick ? 32'd0 : presc_q + 32'd1;
  end

  // Channel next-state. Precedence: the counter step and any event come from
  // the current state; ACK and bus writes are applied next, so a CTRL write
  // overrides a one-shot EN clear; an event's PEND set is applied last so it
  // beats a coincident ACK or STATUS clear.
  always_comb begin
    period_d  = period_q;
    count_d   = count_q;
    en_d      = en_q;
    oneshot_d = oneshot_q;
    ie_d      = ie_q;
    pend_d    = pend_q;
    fire      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (tick && en_q[c] && (period_q[c] != 16'd0)) begin
        if (count_q[c] >= period_q[c] - 16'd1) begin
          count_d[c] = 16'd0;
          fire[c]    = 1'b1;
        end else begin
          count_d[c] = count_q[c] + 16'd1;
        end
      end
      if (fire[c] && oneshot_q[c]) begin
        en_d[c] = 1'b0;
      end
      if (BUS_INTERRUPTS_ACK[c]) begin
        pend_d[c] = 1'b0;
      end
      if (ch_wr[c]) begin
        case (sel_reg)
          2'd0: period_d[c][7:0]  = BUS_DATA;
          2'd1: period_d[c][15:8] = BUS_DATA;
          2'd2: begin
            if (!en_q[c] && BUS_DATA[0]) begin
              count_d[c] = 16'd0;
            end
            en_d[c]      = BUS_DATA[0];
            oneshot_d[c] = BUS_DATA[1];
            ie_d[c]      = BUS_DATA[2];
          end
          default: begin
            count_d[c] = 16'd0;
            if (BUS_DATA[0]) begin
              pend_d[c] = 1'b0;
            end
          end
        endcase
      end
      if (fire[c]) begin
        pend_d[c] = 1'b1;
      end
    end
  end

  always_comb begin
    raise_d = pend_q & ie_q;
  end

  // Read mux from the current register values.
  always_comb begin
    rd_value = 8'h00;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_ch == 2'(c)) begin
        case (sel_reg)
          2'd0:    rd_value = period_q[c][7:0];
          2'd1:    rd_value = period_q[c][15:8];
          2'd2:    rd_value = {5'b0, ie_q[c], oneshot_q[c], en_q[c]};
          default: rd_value = {6'b0, en_q[c], pend_q[c]};
        endcase
      end
    end
  end

  // One-cycle read latency: capture on the edge, drive for the following cycle.
  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_en ? rd_value : 8'h00;
  end

  assign BUS_DATA             = rd_valid_q ? rd_data_q : 8'hzz;
  assign BUS_INTERRUPTS_RAISE = raise_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc_q    <= '0;
      period_q   <= '0;
      count_q    <= '0;
      en_q       <= '0;
      oneshot_q  <= '0;
      ie_q       <= '0;
      pend_q     <= '0;
      raise_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      period_q   <= period_d;
      count_q    <= count_d;
      en_q       <= en_d;
      oneshot_q  <= oneshot_d;
      ie_q       <= ie_d;
      pend_q     <= pend_d;
      raise_q    <= raise_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule
